// File: rtl/set_pkg.sv
// Shared widths, host state encoding and the job descriptor layout for the
// SET host sequencer.
package set_pkg;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;
    localparam int TAG_W     = 4;

    // Host sequencer states: wait for work, start the engine, wait for its
    // result (or the watchdog), then hold the result for downstream.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } host_state_t;

    // One queued job: operands for the engine plus the tag assigned at push.
    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [MODE_W-1:0]    mode;
        logic [RADIUS_W-1:0]  radius;
        logic [CENTRAL_W-1:0] central;
    } job_t;

    localparam int JOB_W = $bits(job_t);

endpackage

// File: rtl/set_job_fifo.sv
// Job FIFO for the SET host: DEPTH entries of job_t, registered pointers and
// occupancy count, first-word fall-through head.
module set_job_fifo
    import set_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic pop,
    input  job_t wr_data,
    output logic full,
    output logic empty,
    output job_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full/empty come straight from the registered count, so a pop in the
    // same cycle never opens a slot for a push that cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write.
    // NOTE: the data array is deliberately left out of reset; only pointers and
    // count need a known value, and an unreset array maps to plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/set_host.sv
// Host-side sequencer for the SET candidate-counting engine: queues jobs,
// issues them one at a time over en/busy/valid, captures the count with its
// tag, and abandons jobs whose engine never answers.
module set_host
    import set_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [CENTRAL_W-1:0] job_central_i,
    input  logic [RADIUS_W-1:0]  job_radius_i,
    input  logic [MODE_W-1:0]    job_mode_i,
    output logic                 en_o,
    output logic [CENTRAL_W-1:0] central_o,
    output logic [RADIUS_W-1:0]  radius_o,
    output logic [MODE_W-1:0]    mode_o,
    input  logic                 busy_i,
    input  logic                 valid_i,
    input  logic [CAND_W-1:0]    candidate_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [CAND_W-1:0]    res_candidate_o,
    output logic [TAG_W-1:0]     res_tag_o,
    output logic                 res_err_o,
    output logic                 err_sticky_o
);

    localparam int WD_W = 6;

    host_state_t      state;
    host_state_t      state_nx;
    logic [WD_W-1:0]  wd_cnt;
    logic [TAG_W-1:0] tag_cnt;
    job_t             wr_job;
    job_t             head_job;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             take_result;
    logic             take_timeout;

    assign job_ready_o = !fifo_full;
    assign push        = job_valid_i && !fifo_full;
    assign wr_job      = '{tag: tag_cnt, mode: job_mode_i,
                           radius: job_radius_i, central: job_central_i};

    set_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_job),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_job)
    );

    // Operands mirror the FIFO head; masked while empty so reset shows zeros
    // instead of stale storage.
    assign central_o = fifo_empty ? '0 : head_job.central;
    assign radius_o  = fifo_empty ? '0 : head_job.radius;
    assign mode_o    = fifo_empty ? '0 : head_job.mode;

    assign en_o        = (state == ISSUE);
    assign res_valid_o = (state == OUT);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic plus the pop/capture strobes that leave WAIT.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !busy_i) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (valid_i) begin
                    take_result = 1'b1;
                    pop         = 1'b1;
                    state_nx    = OUT;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    take_timeout = 1'b1;
                    pop          = 1'b1;
                    state_nx     = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Watchdog: cleared when the engine is started, counts WAIT cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Tag counter: each accepted job takes the current value, then it wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_cnt <= '0;
        end else if (push) begin
            tag_cnt <= tag_cnt + 1'b1;
        end
    end

    // Result registers: loaded once per job when WAIT exits, held through OUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_candidate_o <= '0;
            res_tag_o       <= '0;
            res_err_o       <= 1'b0;
        end else if (take_result) begin
            res_candidate_o <= candidate_i;
            res_tag_o       <= head_job.tag;
            res_err_o       <= 1'b0;
        end else if (take_timeout) begin
            res_candidate_o <= '0;
            res_tag_o       <= head_job.tag;
            res_err_o       <= 1'b1;
        end
    end

    // Sticky error: any timeout, or a result strobe arriving outside WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_sticky_o <= 1'b0;
        end else if (take_timeout || (valid_i && (state != WAIT))) begin
            err_sticky_o <= 1'b1;
        end
    end

endmodule
